guihca_acc_capture: RTL and testbench
=====================================

Name: guihca_acc_capture

Overview:
- Parametrised successor to the team's registered 8-bit adder datapath.
- Adds selectable arithmetic modes: add, accumulate, subtract.
- Adds a prescaled serial capture engine that samples one input bit into a DEPTH-bit buffer for later readback.
- Sits directly behind the tt_um top-level pins: ui_in feeds a_in, uio_in feeds b_in, and result drives uo_out.

Parameters:
- WIDTH, 8: datapath width of operands and result.
- DEPTH, 64: number of bits in the serial capture buffer (power of two, ≥2).
- MAX_COUNT, 10_000_000: prescaler period in clk cycles between capture samples (≥1).

Ports:
- clk  input  1  single clock; all logic on its rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- ena  input  1  global enable; when 0, all state holds (prescaler included).
- a_in  input  WIDTH  operand A.
- b_in  input  WIDTH  operand B.
- mode  input  2  00 add, 01 accumulate, 10 subtract, 11 hold.
- sample_bit  input  1  serial data bit to capture.
- cap_start  input  1  one-cycle pulse that starts a capture.
- cap_addr  input  log2(DEPTH)  readback index.
- result  output  WIDTH  registered arithmetic result.
- carry  output  1  registered carry-out (add/acc) or borrow (sub).
- cap_busy  output  1  high while the capture is in progress.
- cap_done  output  1  sticky; high once the buffer is full.
- cap_data  output  1  registered buffer[cap_addr].

Behaviour:
- Reset (rst_n=0 at a clk edge) clears the following: result=0, carry=0, accumulator=0, buffer=0, state=IDLE, prescaler=0, bit counter=0, cap_busy=0, cap_done=0, cap_data=0. Reset overrides ena.
- Arithmetic has a latency of 1 cycle. The sum is computed in WIDTH+1 bits, and wrap-around is modulo 2^WIDTH.
  - mode 00: {carry,result} <= a_in + b_in.
  - mode 01: {carry,acc} <= acc + a_in; result mirrors acc. The accumulator is internal, and result equals acc after every mode-01 cycle.
  - mode 10: result <= a_in - b_in; carry <= (a_in < b_in).
  - mode 11: result and carry hold.
  - Modes 00 and 10 do not disturb acc.
- Prescaler:
  - Counts 0..MAX_COUNT-1 while state=CAPTURE and ena=1.
  - tick is asserted when count == MAX_COUNT-1, after which the count wraps to 0.
  - With MAX_COUNT=1, tick is asserted every cycle.
  - The prescaler is forced to 0 outside CAPTURE.
- Capture FSM:
  - IDLE: on cap_start, clear bit counter and prescaler, clear cap_done, go to CAPTURE.
  - CAPTURE: cap_busy=1. On tick, buffer[counter] <= sample_bit and the counter increments. When the sample is written at index DEPTH-1, go to DONE.
  - DONE: cap_busy=0, cap_done=1. cap_start restarts (same as IDLE).
- cap_start received during CAPTURE is ignored; there is no restart mid-capture.
- The first sample is taken MAX_COUNT cycles after the cycle in which cap_start is registered.
- cap_data <= buffer[cap_addr] every enabled cycle (1-cycle read latency). A read of an address being written in the same cycle returns the old value.
- The buffer is retained across captures until overwritten; bits not yet rewritten keep their prior values.
- ena=0 freezes every register, including cap_data.
- Reset mid-capture returns to IDLE with the buffer cleared.

Decomposition:
- Shared package guihca_pkg holds:
  - mode encodings MODE_ADD, MODE_ACC, MODE_SUB, MODE_HOLD;
  - capture state enum {ST_IDLE, ST_CAPTURE, ST_DONE};
  - function clog2-based width helper.
- One sub-module is natural: guihca_prescaler (parameter MAX_COUNT; inputs clk, rst_n, run; output tick). It is reusable by other tt_um blocks needing slow ticks.
- The arithmetic and capture logic stay in the parent.

Test Plan:
- Add with wrap: WIDTH=8, mode=00, a=0xF0, b=0x20 → next cycle result=0x10, carry=1. Then a=3, b=4 → result=0x07, carry=0.
- Accumulate: reset, mode=01, a=0x40 for 4 cycles → result 0x40, 0x80, 0xC0, then 0x00 with carry=1. Switch to mode=00 for 1 cycle, then mode=01 with a=1 → result=0x01 (acc preserved at 0x00).
- Subtract and hold: mode=10, a=5, b=7 → result=0xFE, carry=1. mode=11 for 3 cycles → result stays 0xFE, carry stays 1.
- Capture:
  - Setup: MAX_COUNT=3, DEPTH=8, pulse cap_start, drive sample_bit with pattern 1,0,1,1,0,0,1,0 changing every 3 cycles.
  - Required response: cap_busy high for 24 cycles, then cap_done=1.
  - Readback: cap_addr 0..7 reads back the pattern with 1-cycle latency.
- Ignored restart and ena freeze:
  - cap_start pulsed mid-capture → completion time unchanged.
  - ena=0 for 10 cycles mid-capture → cap_done is delayed by exactly 10 cycles, and result is unchanged throughout.
- Synchronous reset mid-capture: assert rst_n=0 for 1 cycle at sample 4 → next cycle cap_busy=0, cap_done=0, all cap_data reads=0, result=0.

Source files
------------

// File: rtl/guihca_pkg.sv
// Shared encodings and helpers for the guihca arithmetic/capture block
// and any tt_um siblings that reuse its prescaler.
package guihca_pkg;

    localparam logic [1:0] MODE_ADD  = 2'b00;
    localparam logic [1:0] MODE_ACC  = 2'b01;
    localparam logic [1:0] MODE_SUB  = 2'b10;
    localparam logic [1:0] MODE_HOLD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CAPTURE,
        ST_DONE
    } cap_state_t;

    // Index/counter width for a range of n values, never narrower than one bit.
    function automatic int addr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/guihca_prescaler.sv
// Free-running divider: while run is high it counts 0..MAX_COUNT-1 and pulses tick on the last count.
// The counter holds when run is low; the parent clears it through rst_n.
module guihca_prescaler
    import guihca_pkg::*;
#(
    parameter int MAX_COUNT = 10_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic tick
);

    localparam int              CW   = addr_w(MAX_COUNT);
    localparam logic [CW-1:0]   LAST = CW'(MAX_COUNT - 1);

    logic [CW-1:0] count;

    assign tick = run && (count == LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (run) begin
            count <= tick ? '0 : count + CW'(1);
        end
    end

endmodule

// File: rtl/guihca_acc_capture.sv
// Registered add/accumulate/subtract datapath plus a prescaled serial
// capture engine that fills a DEPTH-bit buffer for indexed readback.
module guihca_acc_capture
    import guihca_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 64,
    parameter int MAX_COUNT = 10_000_000
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       ena,
    input  logic [WIDTH-1:0]           a_in,
    input  logic [WIDTH-1:0]           b_in,
    input  logic [1:0]                 mode,
    input  logic                       sample_bit,
    input  logic                       cap_start,
    input  logic [addr_w(DEPTH)-1:0]   cap_addr,
    output logic [WIDTH-1:0]           result,
    output logic                       carry,
    output logic                       cap_busy,
    output logic                       cap_done,
    output logic                       cap_data
);

    localparam int AW = addr_w(DEPTH);

    logic [WIDTH-1:0] acc;
    logic [WIDTH:0]   sum_ab;
    logic [WIDTH:0]   sum_acc;
    logic [WIDTH:0]   diff;

    assign sum_ab  = {1'b0, a_in} + {1'b0, b_in};
    assign sum_acc = {1'b0, acc}  + {1'b0, a_in};
    // The extra top bit of an unsigned WIDTH+1 subtraction is exactly the borrow (a_in < b_in).
    assign diff    = {1'b0, a_in} - {1'b0, b_in};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            result <= '0;
            carry  <= 1'b0;
            acc    <= '0;
        end else if (ena) begin
            case (mode)
                MODE_ADD: {carry, result} <= sum_ab;
                MODE_ACC: begin
                    {carry, acc} <= sum_acc;
                    result       <= sum_acc[WIDTH-1:0];
                end
                MODE_SUB: {carry, result} <= diff;
                MODE_HOLD: ;
            endcase
        end
    end

    cap_state_t     state;
    logic [AW-1:0]  bit_cnt;
    logic [DEPTH-1:0] buffer;
    logic           tick;
    logic           presc_run;
    logic           presc_rst_n;

    // Holding under ena=0 comes from run dropping; clearing outside CAPTURE is folded into its sync reset.
    assign presc_run   = ena && (state == ST_CAPTURE);
    assign presc_rst_n = rst_n && !(ena && (state != ST_CAPTURE));

    guihca_prescaler #(
        .MAX_COUNT (MAX_COUNT)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (presc_rst_n),
        .run   (presc_run),
        .tick  (tick)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            bit_cnt  <= '0;
            buffer   <= '0;
            cap_busy <= 1'b0;
            cap_done <= 1'b0;
            cap_data <= 1'b0;
        end else if (ena) begin
            cap_data <= buffer[cap_addr];
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (cap_start) begin
                        bit_cnt  <= '0;
                        cap_done <= 1'b0;
                        cap_busy <= 1'b1;
                        state    <= ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    if (tick) begin
                        buffer[bit_cnt] <= sample_bit;
                        bit_cnt         <= bit_cnt + AW'(1);
                        if (bit_cnt == AW'(DEPTH - 1)) begin
                            state    <= ST_DONE;
                            cap_busy <= 1'b0;
                            cap_done <= 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_guihca_acc_capture.sv
// Self-checking bench for guihca_acc_capture with WIDTH=8, DEPTH=8, MAX_COUNT=3.
// Expected values come from a small behavioural model feeding scoreboard queues.
module tb_guihca_acc_capture;

    localparam int WIDTH     = 8;
    localparam int DEPTH     = 8;
    localparam int MAX_COUNT = 3;

    logic             clk;
    logic             rst_n;
    logic             ena;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic [1:0]       mode;
    logic             sample_bit;
    logic             cap_start;
    logic [2:0]       cap_addr;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             cap_busy;
    logic             cap_done;
    logic             cap_data;

    guihca_acc_capture #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .MAX_COUNT (MAX_COUNT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .a_in       (a_in),
        .b_in       (b_in),
        .mode       (mode),
        .sample_bit (sample_bit),
        .cap_start  (cap_start),
        .cap_addr   (cap_addr),
        .result     (result),
        .carry      (carry),
        .cap_busy   (cap_busy),
        .cap_done   (cap_done),
        .cap_data   (cap_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] r;
        logic             c;
    } arith_exp_t;

    arith_exp_t arith_q[$];
    logic       bit_q[$];

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [WIDTH-1:0] m_acc;
    logic [WIDTH-1:0] m_res;
    logic             m_car;

    task automatic model_reset();
        m_acc = '0;
        m_res = '0;
        m_car = 1'b0;
    endtask

    task automatic arith_step(input logic [1:0] md, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                              input string name);
        logic [WIDTH:0] t;
        arith_exp_t e;
        arith_exp_t got;
        mode = md;
        a_in = a;
        b_in = b;
        case (md)
            2'b00: begin
                t = {1'b0, a} + {1'b0, b};
                m_res = t[WIDTH-1:0];
                m_car = t[WIDTH];
            end
            2'b01: begin
                t = {1'b0, m_acc} + {1'b0, a};
                m_acc = t[WIDTH-1:0];
                m_res = m_acc;
                m_car = t[WIDTH];
            end
            2'b10: begin
                m_res = a - b;
                m_car = (a < b);
            end
            default: ;
        endcase
        e.r = m_res;
        e.c = m_car;
        arith_q.push_back(e);
        @(posedge clk); #1;
        got = arith_q.pop_front();
        total_cnt++;
        if (result !== got.r || carry !== got.c) begin
            $display("FAIL %s: result=%h carry=%b, expected result=%h carry=%b", name, result, carry, got.r, got.c);
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic check_bit(input logic actual, input logic expected, input string name);
        total_cnt++;
        if (actual !== expected) begin
            $display("FAIL %s: got %b expected %b", name, actual, expected);
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic readback(input logic [7:0] pat, input string name);
        logic e;
        for (int i = 0; i < DEPTH; i++) begin
            cap_addr = 3'(i);
            bit_q.push_back(pat[i]);
            @(posedge clk); #1;
            e = bit_q.pop_front();
            total_cnt++;
            if (cap_data !== e) begin
                $display("FAIL %s[%0d]: cap_data=%b expected %b", name, i, cap_data, e);
            end else begin
                pass_cnt++;
            end
        end
    endtask

    // Starts a capture and drives pat[k] so it is present at the k-th prescaler tick.
    task automatic run_capture(input logic [7:0] pat, input int restart_at, input int freeze_at,
                               input int freeze_len, input int stop_at, output int cycles);
        int s;
        logic [WIDTH-1:0] held;
        mode      = 2'b11;
        ena       = 1'b1;
        cap_start = 1'b1;
        @(posedge clk); #1;
        cap_start = 1'b0;
        check_bit(cap_busy, 1'b1, "busy_after_start");
        check_bit(cap_done, 1'b0, "done_clear_after_start");
        cycles = 0;
        s      = 0;
        held   = result;
        while (cap_busy && cycles < 200 && cycles != stop_at) begin
            if (cycles >= freeze_at && cycles < freeze_at + freeze_len) begin
                ena  = 1'b0;
                mode = 2'b00;
                a_in = 8'h55;
                b_in = 8'h11;
            end else begin
                ena  = 1'b1;
                mode = 2'b11;
            end
            cap_start  = (cycles == restart_at);
            sample_bit = (s / 3 < 8) ? pat[s / 3] : 1'b0;
            @(posedge clk); #1;
            if (ena) s++;
            if (!ena) begin
                total_cnt++;
                if (result !== held) begin
                    $display("FAIL freeze_result: result=%h expected %h", result, held);
                end else begin
                    pass_cnt++;
                end
            end
            cycles++;
        end
        ena       = 1'b1;
        mode      = 2'b11;
        cap_start = 1'b0;
        if (cycles >= 200) begin
            total_cnt++;
            $display("FAIL capture_timeout: busy for %0d cycles, expected completion within 200", cycles);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
        total_cnt++;
        if (result !== 8'h00 || carry !== 1'b0) begin
            $display("FAIL reset_arith: result=%h carry=%b expected 00/0", result, carry);
        end else begin
            pass_cnt++;
        end
        check_bit(cap_busy, 1'b0, "reset_busy");
        check_bit(cap_done, 1'b0, "reset_done");
        check_bit(cap_data, 1'b0, "reset_data");
        readback(8'h00, "reset_buf");
    endtask

    task automatic test_add();
        arith_step(2'b00, 8'hF0, 8'h20, "add_wrap");
        arith_step(2'b00, 8'h03, 8'h04, "add_small");
    endtask

    task automatic test_accumulate();
        pulse_reset();
        for (int i = 0; i < 4; i++) arith_step(2'b01, 8'h40, 8'h00, "acc_step");
        arith_step(2'b00, 8'h12, 8'h34, "acc_interleave_add");
        arith_step(2'b01, 8'h01, 8'h00, "acc_preserved");
    endtask

    task automatic test_sub_hold();
        arith_step(2'b10, 8'h05, 8'h07, "sub_borrow");
        for (int i = 0; i < 3; i++) arith_step(2'b11, 8'hAA, 8'h01, "hold");
        arith_step(2'b10, 8'h09, 8'h02, "sub_no_borrow");
    endtask

    task automatic test_capture();
        int cyc;
        run_capture(8'h4D, -1, -1, 0, -1, cyc);
        total_cnt++;
        if (cyc !== 24) begin
            $display("FAIL capture_busy_len: busy %0d cycles expected 24", cyc);
        end else begin
            pass_cnt++;
        end
        check_bit(cap_done, 1'b1, "capture_done");
        readback(8'h4D, "capture_buf");
    endtask

    task automatic test_restart_ignored();
        int cyc;
        run_capture(8'hB2, 10, -1, 0, -1, cyc);
        total_cnt++;
        if (cyc !== 24) begin
            $display("FAIL restart_busy_len: busy %0d cycles expected 24", cyc);
        end else begin
            pass_cnt++;
        end
        check_bit(cap_done, 1'b1, "restart_done");
        readback(8'hB2, "restart_buf");
    endtask

    task automatic test_ena_freeze();
        int cyc;
        run_capture(8'h3C, 7, 7, 10, -1, cyc);
        total_cnt++;
        if (cyc !== 34) begin
            $display("FAIL freeze_busy_len: busy %0d cycles expected 34", cyc);
        end else begin
            pass_cnt++;
        end
        check_bit(cap_done, 1'b1, "freeze_done");
        readback(8'h3C, "freeze_buf");
    endtask

    task automatic test_reset_mid_capture();
        int cyc;
        arith_step(2'b00, 8'h10, 8'h20, "pre_reset_add");
        run_capture(8'hFF, -1, -1, 0, 12, cyc);
        pulse_reset();
        total_cnt++;
        if (result !== 8'h00 || carry !== 1'b0) begin
            $display("FAIL midreset_arith: result=%h carry=%b expected 00/0", result, carry);
        end else begin
            pass_cnt++;
        end
        check_bit(cap_busy, 1'b0, "midreset_busy");
        check_bit(cap_done, 1'b0, "midreset_done");
        readback(8'h00, "midreset_buf");
    endtask

    initial begin
        rst_n      = 1'b0;
        ena        = 1'b1;
        a_in       = '0;
        b_in       = '0;
        mode       = 2'b11;
        sample_bit = 1'b0;
        cap_start  = 1'b0;
        cap_addr   = '0;
        model_reset();
        @(posedge clk); #1;
        test_reset();
        test_add();
        test_accumulate();
        test_sub_hold();
        test_capture();
        test_restart_ignored();
        test_ena_freeze();
        test_reset_mid_capture();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
